// File: rtl/serial_addsub_pkg.sv
// Shared definitions for serial_addsub: FSM state encoding and the signed
// saturation limits used by the optional SERIAL_ADDSUB_SAT_EN build.
package serial_addsub_pkg;

    localparam int unsigned SAT_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Returns 0x7F..F (positive=1) or 0x80..0 (positive=0) for the given
    // width, right-aligned in a SAT_MAX_W vector; callers truncate to width.
    function automatic logic [SAT_MAX_W-1:0] sat_limit(input int unsigned width,
                                                       input logic        positive);
        logic [SAT_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < int'(SAT_MAX_W); i++) begin
            if (i < int'(width) - 1) begin
                v[i] = positive;
            end else if (i == int'(width) - 1) begin
                v[i] = ~positive;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/serial_addsub_digit.sv
// Combinational DIGIT-bit ripple adder used by serial_addsub for one digit
// per cycle; also exposes the carry into its MSB for overflow detection.
module serial_addsub_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_cin,
    output logic [DIGIT-1:0] o_sum,
    output logic             o_cout,
    output logic             o_cmsb
);

    logic [DIGIT:0] w_c;

    always_comb begin
        w_c    = '0;
        o_sum  = '0;
        w_c[0] = i_cin;
        for (int i = 0; i < DIGIT; i++) begin
            o_sum[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
            w_c[i + 1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
        end
    end

    assign o_cout = w_c[DIGIT];
    assign o_cmsb = w_c[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial add/subtract, LSB digit first, WIDTH/DIGIT cycles per operation.
// Define SERIAL_ADDSUB_SAT_EN to saturate the signed result on overflow.
//
//   state | meaning
//   IDLE  | waiting for start; operands captured on acceptance
//   RUN   | one DIGIT-bit slice added per cycle, result shifted in from the MSB end
//   DONE  | result held; done raised one cycle after entry; leaves when start=0
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    // DIGIT must divide WIDTH; WIDTH is limited to SAT_MAX_W when saturating.
    localparam int            NDIG = WIDTH / DIGIT;
    localparam int            CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_out;
    logic             r_carry;
    logic [CW-1:0]    r_count;
    logic             r_carry_out;
    logic             r_overflow;
    logic             r_done;

    logic [DIGIT-1:0] w_sum;
    logic             w_cout;
    logic             w_cmsb;
    logic             w_last;
    logic             w_ovf;
    logic [WIDTH-1:0] w_out_shift;
    logic [WIDTH-1:0] w_out_final;

    serial_addsub_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .i_a    (r_a[DIGIT-1:0]),
        .i_b    (r_b[DIGIT-1:0]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout),
        .o_cmsb (w_cmsb)
    );

    assign w_last      = (r_count == LAST);
    assign w_ovf       = w_cmsb ^ w_cout;
    assign w_out_shift = (r_out >> DIGIT) | (WIDTH'(w_sum) << (WIDTH - DIGIT));

`ifdef SERIAL_ADDSUB_SAT_EN
    // Result MSB set on overflow means two positives wrapped negative.
    always_comb begin
        w_out_final = w_out_shift;
        if (w_ovf) begin
            w_out_final = WIDTH'(sat_limit(WIDTH, w_out_shift[WIDTH-1]));
        end
    end
`else
    assign w_out_final = w_out_shift;
`endif

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (start)           w_state_next = RUN;
            RUN:     if (w_last)          w_state_next = DONE;
            DONE:    if (!start && r_done) w_state_next = IDLE;
            default:                      w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_out       <= '0;
            r_carry     <= 1'b0;
            r_count     <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // done rises the cycle after results land, so they are settled first
            r_done  <= (r_state == DONE) && (w_state_next == DONE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a         <= a;
                        r_b         <= sub ? ~b : b;
                        r_out       <= '0;
                        r_carry     <= sub;
                        r_count     <= '0;
                        r_carry_out <= 1'b0;
                        r_overflow  <= 1'b0;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_carry <= w_cout;
                    if (w_last) begin
                        r_out       <= w_out_final;
                        r_carry_out <= w_cout;
                        r_overflow  <= w_ovf;
                    end else begin
                        r_out   <= w_out_shift;
                        r_count <= r_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out       = r_out;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;
    assign busy      = (r_state == RUN);
    assign done      = r_done;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: an 8-bit/1-bit and a 16-bit/4-bit
// instance, table-driven vectors through a scoreboard plus hand sequences.
module tb_serial_addsub;

`ifdef SERIAL_ADDSUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic        sub;
    logic        sel;
    logic [15:0] a;
    logic [15:0] b;
    logic        start8;
    logic        start16;
    logic [7:0]  out8;
    logic [15:0] out16;
    logic        co8, ov8, busy8, done8;
    logic        co16, ov16, busy16, done16;

    logic [15:0] m_out;
    logic        m_co, m_ov, m_done;

    assign start8  = start & ~sel;
    assign start16 = start & sel;

    serial_addsub #(.WIDTH(8), .DIGIT(1)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub),
        .a(a[7:0]), .b(b[7:0]), .out(out8), .carry_out(co8),
        .overflow(ov8), .busy(busy8), .done(done8)
    );

    serial_addsub #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .sub(sub),
        .a(a), .b(b), .out(out16), .carry_out(co16),
        .overflow(ov16), .busy(busy16), .done(done16)
    );

    always_comb begin
        m_out  = sel ? out16  : {8'h00, out8};
        m_co   = sel ? co16   : co8;
        m_ov   = sel ? ov16   : ov8;
        m_done = sel ? done16 : done8;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic        sub;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] out;
        logic        co;
        logic        ov;
    } vec_t;

    typedef struct {
        logic [15:0] out;
        logic        co;
        logic        ov;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[16];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_out(input logic s_sel, input logic [15:0] wrap,
                                            input logic ov);
        logic [15:0] lim;
        lim = s_sel ? (wrap[15] ? 16'h7FFF : 16'h8000)
                    : (wrap[7]  ? 16'h007F : 16'h0080);
        return (SAT && ov) ? lim : wrap;
    endfunction

    task automatic do_op(input logic s_sel, input logic s_sub,
                         input logic [15:0] s_a, input logic [15:0] s_b,
                         input logic [15:0] e_out, input logic e_co, input logic e_ov,
                         input string nm);
        exp_t e;
        exp_t got;
        int   lat;
        int   exp_lat;
        sel   = s_sel;
        sub   = s_sub;
        a     = s_a;
        b     = s_b;
        start = 1'b1;
        e.out = exp_out(s_sel, e_out, e_ov);
        e.co  = e_co;
        e.ov  = e_ov;
        sb_q.push_back(e);
        exp_lat = s_sel ? 5 : 9;
        @(posedge clk); #1;
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
        sub   = ~s_sub;
        lat   = 0;
        while (!m_done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({nm, " latency"}, lat, exp_lat);
        got = sb_q.pop_front();
        check({nm, " out"}, m_out, got.out);
        check({nm, " carry_out"}, m_co, got.co);
        check({nm, " overflow"}, m_ov, got.ov);
        @(posedge clk); #1;
        check({nm, " done cleared"}, m_done, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int done_seen;

        vecs[0]  = '{1'b0, 1'b0, 16'h0005, 16'h0003, 16'h0008, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 16'h0003, 16'h0005, 16'h00FE, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 16'h007F, 16'h0001, 16'h0080, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 16'h00FF, 16'h0001, 16'h0000, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 16'h0080, 16'h0080, 16'h0000, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 16'h0080, 16'h0001, 16'h007F, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 16'h0000, 16'h0001, 16'h00FF, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 16'h007F, 16'h00FF, 16'h0080, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 16'h00A5, 16'h005A, 16'h00FF, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 16'h00C0, 16'h00C0, 16'h0080, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 16'h1234, 16'h0235, 16'h0FFF, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};

        rst   = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        sel   = 1'b0;
        a     = 16'h0;
        b     = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset out8", out8, 8'h00);
        check("reset carry8", co8, 1'b0);
        check("reset ovf8", ov8, 1'b0);
        check("reset busy8", busy8, 1'b0);
        check("reset done8", done8, 1'b0);
        check("reset out16", out16, 16'h0000);
        check("reset busy16", busy16, 1'b0);
        check("reset done16", done16, 1'b0);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            do_op(vecs[i].sel, vecs[i].sub, vecs[i].a, vecs[i].b,
                  vecs[i].out, vecs[i].co, vecs[i].ov, $sformatf("vec%0d", i));
        end

        // start held high through RUN and DONE: no restart, result held
        sel = 1'b0; sub = 1'b0; a = 16'h0010; b = 16'h0020; start = 1'b1;
        @(posedge clk); #1;
        check("hold busy after accept", busy8, 1'b1);
        a = 16'h00AA; b = 16'h0055; sub = 1'b1;
        lat = 0;
        while (!done8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("hold latency", lat, 9);
        check("hold out", out8, 8'h30);
        repeat (12) @(posedge clk);
        #1;
        check("hold done stays", done8, 1'b1);
        check("hold no rerun", busy8, 1'b0);
        check("hold out stable", out8, 8'h30);
        start = 1'b0;
        @(posedge clk); #1;
        check("release done low", done8, 1'b0);
        check("release busy low", busy8, 1'b0);
        check("release out held", out8, 8'h30);

        // async reset in the third RUN cycle
        sel = 1'b0; sub = 1'b0; a = 16'h00A5; b = 16'h005A; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort partial out", out8, 8'hC0);
        check("abort busy before", busy8, 1'b1);
        rst = 1'b0;
        #1;
        check("abort out", out8, 8'h00);
        check("abort carry", co8, 1'b0);
        check("abort ovf", ov8, 1'b0);
        check("abort busy", busy8, 1'b0);
        check("abort done", done8, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        done_seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8 || busy8) done_seen++;
        end
        check("abort no done", done_seen, 0);
        do_op(1'b0, 1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, "after abort");

        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard leftover: got %0d entries expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
